pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the fetch stage. It holds the PC and generates sequential, branch, jump and jump-register targets, generalising the fixed 26-bit-index/4-bit-region jump address computation to any address width and alignment. It buffers one pending redirect while fetch is stalled, and traps on a misaligned jump-register target. It sits between the decode/execute redirect sources and instruction memory.

Parameters:
ADDR_W, 32, PC/address width in bits
IDX_W, 26, jump index field width
IMM_W, 16, branch immediate width (sign-extended)
ALIGN, 2, instruction alignment shift (log2 of bytes per instruction)
RESET_VECTOR, 32'h0040_0000, PC after boot

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
fetch_ready  in  1  instruction memory accepts the current pc
pc  out  ADDR_W  current fetch address
pc_valid  out  1  pc is a valid fetch request
redir_valid  in  1  redirect request this cycle
redir_type  in  2  00 branch, 01 jump, 10 jr, 11 reserved (treated as no redirect)
redir_base  in  ADDR_W  PC+step of the redirecting instruction
redir_imm  in  IMM_W  branch offset, in instructions
redir_index  in  IDX_W  jump index field
redir_reg  in  ADDR_W  jr register value
trap  out  1  misaligned jr detected (sticky)
trap_addr  out  ADDR_W  offending jr target

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset (async, any time): pc=RESET_VECTOR, pc_valid=0, trap=0, trap_addr=0, pending cleared, state=BOOT.
- Legality: ADDR_W >= IDX_W+ALIGN is required, with an elaboration-time check.
- Target arithmetic, all modulo 2^ADDR_W:
  - branch = redir_base + (sext(redir_imm) << ALIGN)
  - jump = {redir_base[ADDR_W-1:IDX_W+ALIGN], redir_index, ALIGN zeros}; upper slice is empty when the widths are equal
  - jr = redir_reg
  - sequential = pc + (1<<ALIGN)
- FSM BOOT: pc_valid=0 for exactly one cycle after reset release. Redirects are ignored. Next state is RUN.
- FSM RUN: pc_valid=1.
  - Accept is pc_valid && fetch_ready.
  - On accept, next pc = current-cycle redirect target if present, else pending target if set, else sequential. Pending is cleared on accept.
  - Without accept, pc holds. A valid redirect is written into pending (target computed and registered at capture), and the newest overwrites the older one.
  - Latency: redirect in cycle N with accept gives pc=target in N+1.
- FSM TRAP: entered when a jr redirect has redir_reg[ALIGN-1:0] != 0, whether accepted or stalled.
  - Next cycle: pc_valid=0, trap=1, trap_addr=redir_reg. The pc and pending contents are frozen.
  - Sticky until reset. All inputs are ignored.
- Reserved redir_type: treated as redir_valid=0.
- Simultaneous current-cycle redirect and pending: current wins.

Decomposition:
- Package pc_pkg: redir_type constants (REDIR_BRANCH, REDIR_JUMP, REDIR_JR), FSM state enum (BOOT, RUN, TRAP).
- Sub-module jump_target_gen: purely combinational. Takes type, base, imm, index, reg and outputs target and misalign flag. It is instantiated once, and the FSM/pending register lives in pc_sequencer.

Test Plan:
- Release reset with fetch_ready=1: cycle1 pc_valid=0; cycle2 pc=0x0040_0000, valid=1; then 0x0040_0004, 0x0040_0008.
- Jump, base 0xA000_000C, index 0x010_0040, accepted: next pc=0xA040_0100.
- Branch, base 0x0040_0010, imm 0xFFFC: next pc=0x0040_0000.
- fetch_ready=0 for 3 cycles; jump in stall cycle 1 (target 0x0040_0100), branch in cycle 2 (target 0x0040_0200); pc holds. On ready=1 with no new redirect, next pc=0x0040_0200.
- jr with redir_reg=0x0040_0006: next cycle pc_valid=0, trap=1, trap_addr=0x0040_0006. Hold it 10 cycles with redirects and ready=1: unchanged. Then assert reset: trap=0, back to BOOT.
- Wrap and reset: RESET_VECTOR=0xFFFF_FFFC, accept gives pc=0x0000_0000. Then stall, capture a jump, assert reset mid-stall: pending is discarded, and after BOOT pc=0xFFFF_FFFC.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program-counter sequencer.
//   - Redirect type encodings as driven on redir_type.
//   - FSM state enumeration used by pc_sequencer.
package pc_pkg;

  localparam logic [1:0] REDIR_BRANCH = 2'b00;
  localparam logic [1:0] REDIR_JUMP   = 2'b01;
  localparam logic [1:0] REDIR_JR     = 2'b10;
  localparam logic [1:0] REDIR_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    TRAP = 2'b10
  } pc_state_e;

endpackage

// File: rtl/jump_target_gen.sv
// jump_target_gen: combinational redirect target calculator.
// Ports:
//   redir_type_i  redirect kind (branch / jump / jr / reserved)
//   base_i        PC+step of the redirecting instruction
//   imm_i         branch offset in instructions (sign-extended)
//   index_i       jump index field
//   reg_i         jr register value
//   target_o      computed redirect target (modulo 2^ADDR_W)
//   misalign_o    jr target has non-zero low alignment bits
module jump_target_gen
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 26,
  parameter int IMM_W  = 16,
  parameter int ALIGN  = 2
) (
  input  logic [1:0]        redir_type_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [ADDR_W-1:0] reg_i,
  output logic [ADDR_W-1:0] target_o,
  output logic              misalign_o
);

  // Low bits that must be zero in an instruction address.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = (ADDR_W'(1) << ALIGN) - ADDR_W'(1);
  // Bits of the base that survive a jump. When IDX_W+ALIGN equals ADDR_W
  // the shift yields zero, so the mask collapses to all zeros (empty region).
  localparam logic [ADDR_W-1:0] REGION_MASK =
    ~((ADDR_W'(1) << (IDX_W + ALIGN)) - ADDR_W'(1));

  logic signed [ADDR_W-1:0] imm_sx;
  logic        [ADDR_W-1:0] br_off;
  logic        [ADDR_W-1:0] jmp_tgt;

  always_comb begin
    imm_sx  = ADDR_W'(signed'(imm_i));
    br_off  = imm_sx << ALIGN;
    jmp_tgt = (base_i & REGION_MASK) | (ADDR_W'(index_i) << ALIGN);

    case (redir_type_i)
      REDIR_BRANCH: target_o = base_i + br_off;
      REDIR_JUMP:   target_o = jmp_tgt;
      REDIR_JR:     target_o = reg_i;
      default:      target_o = '0;
    endcase

    misalign_o = (redir_type_i == REDIR_JR) && ((reg_i & ALIGN_MASK) != '0);
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with redirect handling.
// Holds the PC, advances sequentially on fetch accept, applies branch/jump/jr
// redirects, buffers one pending redirect while fetch is stalled, and traps
// (sticky until reset) on a misaligned jr target.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   fetch_ready            instruction memory accepts the current pc
//   pc, pc_valid           fetch request
//   redir_valid/type/base/imm/index/reg   redirect request and operands
//   trap, trap_addr        misaligned-jr trap flag and offending target
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                IDX_W        = 26,
  parameter int                IMM_W        = 16,
  parameter int                ALIGN        = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  input  logic              redir_valid,
  input  logic [1:0]        redir_type,
  input  logic [ADDR_W-1:0] redir_base,
  input  logic [IMM_W-1:0]  redir_imm,
  input  logic [IDX_W-1:0]  redir_index,
  input  logic [ADDR_W-1:0] redir_reg,
  output logic              trap,
  output logic [ADDR_W-1:0] trap_addr
);

  if (ADDR_W < IDX_W + ALIGN) begin : g_bad_widths
    $error("pc_sequencer: ADDR_W must be >= IDX_W + ALIGN");
  end

  localparam logic [ADDR_W-1:0] SEQ_STEP = ADDR_W'(1) << ALIGN;

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [ADDR_W-1:0] trap_addr_q, trap_addr_d;

  logic [ADDR_W-1:0] target;
  logic              misalign;
  logic              redir_take;
  logic              accept;

  jump_target_gen #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W),
    .IMM_W  (IMM_W),
    .ALIGN  (ALIGN)
  ) u_tgt (
    .redir_type_i (redir_type),
    .base_i       (redir_base),
    .imm_i        (redir_imm),
    .index_i      (redir_index),
    .reg_i        (redir_reg),
    .target_o     (target),
    .misalign_o   (misalign)
  );

  // The reserved encoding behaves exactly like no redirect at all.
  assign redir_take = redir_valid && (redir_type != REDIR_RSVD);
  assign accept     = pc_valid && fetch_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN:  if (redir_take && misalign) state_d = TRAP;
      TRAP: state_d = TRAP;
      default: state_d = BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    pc_valid  = (state_q == RUN);
    trap      = (state_q == TRAP);
    pc        = pc_q;
    trap_addr = trap_addr_q;
  end

  // PC / pending-redirect / trap-address datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      pend_vld_q  <= 1'b0;
      pend_tgt_q  <= '0;
      trap_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_vld_q  <= pend_vld_d;
      pend_tgt_q  <= pend_tgt_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  always_comb begin
    pc_d        = pc_q;
    pend_vld_d  = pend_vld_q;
    pend_tgt_d  = pend_tgt_q;
    trap_addr_d = trap_addr_q;
    if (state_q == RUN) begin
      if (redir_take && misalign) begin
        // Trap freezes pc and pending; only the offending address is kept.
        trap_addr_d = redir_reg;
      end else if (accept) begin
        // A redirect arriving this cycle beats an older buffered one.
        if (redir_take)      pc_d = target;
        else if (pend_vld_q) pc_d = pend_tgt_q;
        else                 pc_d = pc_q + SEQ_STEP;
        pend_vld_d = 1'b0;
      end else if (redir_take) begin
        // Stalled: remember the newest redirect target.
        pend_vld_d = 1'b1;
        pend_tgt_d = target;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [31:0] RV0 = 32'h0040_0000;
  localparam logic [31:0] RV1 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_type = 2'b00;
  logic [31:0] redir_base = '0;
  logic [15:0] redir_imm = '0;
  logic [25:0] redir_index = '0;
  logic [31:0] redir_reg = '0;

  logic [31:0] pc0, pc1, ta0, ta1;
  logic        v0, v1, t0, t1;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(.RESET_VECTOR(RV0)) dut0 (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
    .pc(pc0), .pc_valid(v0),
    .redir_valid(redir_valid), .redir_type(redir_type), .redir_base(redir_base),
    .redir_imm(redir_imm), .redir_index(redir_index), .redir_reg(redir_reg),
    .trap(t0), .trap_addr(ta0)
  );

  pc_sequencer #(.RESET_VECTOR(RV1)) dut1 (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
    .pc(pc1), .pc_valid(v1),
    .redir_valid(redir_valid), .redir_type(redir_type), .redir_base(redir_base),
    .redir_imm(redir_imm), .redir_index(redir_index), .redir_reg(redir_reg),
    .trap(t1), .trap_addr(ta1)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // ph: 0 = booting, 1 = fetching, 2 = trapped
  typedef struct packed {
    logic [1:0]  ph;
    logic [31:0] pc;
    logic        has_pend;
    logic [31:0] pend;
    logic [31:0] ta;
  } ms_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        t;
    logic [31:0] ta;
  } obs_t;

  ms_t  ms0, ms1;
  obs_t exp_q0[$];
  obs_t exp_q1[$];

  function automatic logic [31:0] ref_target(logic [1:0] ty, logic [31:0] base,
                                             logic [15:0] imm, logic [25:0] idx,
                                             logic [31:0] rg);
    longint region;
    longint off;
    region = longint'(1) << 28;
    off    = longint'($signed(imm)) * 4;
    case (ty)
      2'd0:    return 32'(longint'(base) + off);
      2'd1:    return 32'((longint'(base) / region) * region + longint'(idx) * 4);
      default: return rg;
    endcase
  endfunction

  function automatic ms_t model_step(ms_t s, logic [31:0] rvec, logic rst, logic rdy,
                                     logic rv, logic [1:0] ty, logic [31:0] base,
                                     logic [15:0] imm, logic [25:0] idx, logic [31:0] rg);
    ms_t   n;
    logic  redir;
    n = s;
    redir = rv && (ty != 2'd3);
    if (rst) begin
      n.ph = 2'd0; n.pc = rvec; n.has_pend = 1'b0; n.pend = '0; n.ta = '0;
    end else if (s.ph == 2'd0) begin
      n.ph = 2'd1;
    end else if (s.ph == 2'd1) begin
      if (redir && ty == 2'd2 && (rg % 4) != 0) begin
        n.ph = 2'd2; n.ta = rg;
      end else if (rdy) begin
        if (redir)           n.pc = ref_target(ty, base, imm, idx, rg);
        else if (s.has_pend) n.pc = s.pend;
        else                 n.pc = 32'(longint'(s.pc) + 4);
        n.has_pend = 1'b0;
      end else if (redir) begin
        n.has_pend = 1'b1;
        n.pend     = ref_target(ty, base, imm, idx, rg);
      end
    end
    return n;
  endfunction

  function automatic obs_t to_obs(ms_t s);
    obs_t o;
    o.v  = (s.ph == 2'd1);
    o.pc = s.pc;
    o.t  = (s.ph == 2'd2);
    o.ta = s.ta;
    return o;
  endfunction

  always @(posedge clk) begin
    exp_q0.push_back(to_obs(model_step(ms0, RV0, reset, fetch_ready, redir_valid, redir_type,
                                       redir_base, redir_imm, redir_index, redir_reg)));
    exp_q1.push_back(to_obs(model_step(ms1, RV1, reset, fetch_ready, redir_valid, redir_type,
                                       redir_base, redir_imm, redir_index, redir_reg)));
    ms0 <= model_step(ms0, RV0, reset, fetch_ready, redir_valid, redir_type,
                      redir_base, redir_imm, redir_index, redir_reg);
    ms1 <= model_step(ms1, RV1, reset, fetch_ready, redir_valid, redir_type,
                      redir_base, redir_imm, redir_index, redir_reg);
  end

  // ---------------- scoreboard monitor ----------------
  task automatic cmp_obs(input string nm, input obs_t e, input obs_t a);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got v=%b pc=%h trap=%b ta=%h, expected v=%b pc=%h trap=%b ta=%h",
               nm, $time, a.v, a.pc, a.t, a.ta, e.v, e.pc, e.t, e.ta);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q0.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb0_empty @%0t: got no expectation, required one", $time);
    end else begin
      cmp_obs("sb_dut0", exp_q0.pop_front(), {v0, pc0, t0, ta0});
    end
    if (exp_q1.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb1_empty @%0t: got no expectation, required one", $time);
    end else begin
      cmp_obs("sb_dut1", exp_q1.pop_front(), {v1, pc1, t1, ta1});
    end
  end

  // ---------------- directed checks and stimulus ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic no_redir();
    redir_valid = 1'b0;
    redir_type  = 2'b00;
  endtask

  task automatic set_redir(input logic [1:0] ty, input logic [31:0] base,
                           input logic [15:0] imm, input logic [25:0] idx,
                           input logic [31:0] rg);
    redir_valid = 1'b1;
    redir_type  = ty;
    redir_base  = base;
    redir_imm   = imm;
    redir_index = idx;
    redir_reg   = rg;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("async_rst_pc0",    pc0, RV0);
    chk("async_rst_pc1",    pc1, RV1);
    chk("async_rst_valid0", 32'(v0), 32'd0);
    chk("async_rst_trap0",  32'(t0), 32'd0);
    chk("async_rst_ta0",    ta0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_redir();
    logic [31:0] rg;
    rg = $urandom;
    if ($urandom_range(0, 15) != 0) rg = rg & 32'hFFFF_FFFC;
    redir_valid = 1'($urandom_range(0, 1));
    redir_type  = 2'($urandom_range(0, 3));
    redir_base  = $urandom;
    redir_imm   = 16'($urandom);
    redir_index = 26'($urandom);
    redir_reg   = rg;
  endtask

  initial begin
    ms0 = '0;
    ms1 = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Boot and sequential fetch
    reset = 1'b0;
    fetch_ready = 1'b1;
    chk("boot_valid0", 32'(v0), 32'd0);
    @(negedge clk);
    chk("boot_pc0", pc0, 32'h0040_0000);
    chk("boot_valid0_run", 32'(v0), 32'd1);
    chk("boot_pc1_vec", pc1, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("seq_pc0_1", pc0, 32'h0040_0004);
    chk("wrap_pc1", pc1, 32'h0000_0000);
    @(negedge clk);
    chk("seq_pc0_2", pc0, 32'h0040_0008);

    // Jump then branch, both accepted
    set_redir(2'd1, 32'hA000_000C, 16'h0, 26'h010_0040, 32'h0);
    @(negedge clk);
    chk("jump_pc0", pc0, 32'hA040_0100);
    set_redir(2'd0, 32'h0040_0010, 16'hFFFC, 26'h0, 32'h0);
    @(negedge clk);
    chk("branch_pc0", pc0, 32'h0040_0000);

    // Stall: newest captured redirect wins on release
    fetch_ready = 1'b0;
    set_redir(2'd1, 32'h0040_0000, 16'h0, 26'h010_0040, 32'h0);
    @(negedge clk);
    chk("stall_hold1", pc0, 32'h0040_0000);
    set_redir(2'd0, 32'h0040_0000, 16'h0080, 26'h0, 32'h0);
    @(negedge clk);
    chk("stall_hold2", pc0, 32'h0040_0000);
    no_redir();
    @(negedge clk);
    chk("stall_hold3", pc0, 32'h0040_0000);
    fetch_ready = 1'b1;
    @(negedge clk);
    chk("pending_pc0", pc0, 32'h0040_0200);

    // Misaligned jr traps and stays trapped
    set_redir(2'd2, 32'h0, 16'h0, 26'h0, 32'h0040_0006);
    @(negedge clk);
    chk("trap_flag0", 32'(t0), 32'd1);
    chk("trap_valid0", 32'(v0), 32'd0);
    chk("trap_addr0", ta0, 32'h0040_0006);
    for (int i = 0; i < 10; i++) begin
      rand_redir();
      @(negedge clk);
    end
    no_redir();
    chk("trap_sticky0", 32'(t0), 32'd1);
    chk("trap_addr_sticky0", ta0, 32'h0040_0006);
    chk("trap_pc_frozen0", pc0, 32'h0040_0200);
    do_reset();
    chk("post_trap_flag0", 32'(t0), 32'd0);

    // Wrap, then reset during a stall discards the pending jump
    @(negedge clk);
    chk("wrap_vec_pc1", pc1, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_zero_pc1", pc1, 32'h0000_0000);
    fetch_ready = 1'b0;
    set_redir(2'd1, 32'h0, 16'h0, 26'h000_0123, 32'h0);
    @(negedge clk);
    no_redir();
    @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("rst_stall_pc1", pc1, 32'hFFFF_FFFC);
    fetch_ready = 1'b1;
    @(negedge clk);
    chk("rst_no_pending_pc1", pc1, 32'h0000_0000);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        no_redir();
        do_reset();
      end else begin
        fetch_ready = ($urandom_range(0, 3) != 0);
        rand_redir();
        @(negedge clk);
      end
    end
    no_redir();
    repeat (3) @(negedge clk);

    n_tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d/%0d leftover expectations, required 0/0",
               exp_q0.size(), exp_q1.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
